// File: rtl/seg_scan_blink.sv
// Eight-digit multiplexed seven-segment driver with frame-synchronous shadow
// registers and per-digit blinking. All outputs are active-low and registered.
module seg_scan_blink #(
    parameter int unsigned SCAN_TICKS   = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] data,
    input  logic [7:0]  blink,
    input  logic [7:0]  dp,
    output logic [7:0]  AN,
    output logic [7:0]  SEG
);

    localparam int unsigned PW     = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_TICKS - 1);
    localparam logic [7:0]    F_LAST = 8'(BLINK_FRAMES - 1);

    logic [PW-1:0] p_q, p_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    f_q, f_d;
    logic          ph_q, ph_d;

    logic [31:0]   sh_data_q, sh_data_d;
    logic [7:0]    sh_blink_q, sh_blink_d;
    logic [7:0]    sh_dp_q, sh_dp_d;

    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic          scan_wrap;
    logic          frame_end;
    logic          dark;
    logic [3:0]    nib;
    logic [6:0]    seg7;

    // Scan timing: prescaler, digit index, frame counter and blink phase.
    always_comb begin
        scan_wrap = (p_q == P_LAST);
        frame_end = scan_wrap && (idx_q == 3'd7);

        p_d   = scan_wrap ? '0 : p_q + 1'b1;
        idx_d = scan_wrap ? idx_q + 3'd1 : idx_q;

        f_d  = f_q;
        ph_d = ph_q;
        if (frame_end) begin
            if (f_q == F_LAST) begin
                f_d  = 8'd0;
                ph_d = ~ph_q;
            end else begin
                f_d = f_q + 8'd1;
            end
        end
    end

    // Shadows only move at frame end so a frame never mixes old and new data.
    always_comb begin
        sh_data_d  = sh_data_q;
        sh_blink_d = sh_blink_q;
        sh_dp_d    = sh_dp_q;
        if (frame_end) begin
            sh_data_d  = data;
            sh_blink_d = blink;
            sh_dp_d    = dp;
        end
    end

    always_comb begin
        nib = sh_data_q[{idx_q, 2'b00} +: 4];
        unique case (nib)
            4'h0:    seg7 = 7'h40;
            4'h1:    seg7 = 7'h79;
            4'h2:    seg7 = 7'h24;
            4'h3:    seg7 = 7'h30;
            4'h4:    seg7 = 7'h19;
            4'h5:    seg7 = 7'h12;
            4'h6:    seg7 = 7'h02;
            4'h7:    seg7 = 7'h78;
            4'h8:    seg7 = 7'h00;
            4'h9:    seg7 = 7'h10;
            4'hA:    seg7 = 7'h08;
            4'hB:    seg7 = 7'h03;
            4'hC:    seg7 = 7'h46;
            4'hD:    seg7 = 7'h21;
            4'hE:    seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    end

    // Outputs are computed from the pre-edge state, giving one cycle of latency.
    always_comb begin
        dark = !en || (ph_q && sh_blink_q[idx_q]);
        if (dark) begin
            an_d  = 8'hFF;
            seg_d = 8'hFF;
        end else begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = {~sh_dp_q[idx_q], seg7};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q        <= '0;
            idx_q      <= 3'd0;
            f_q        <= 8'd0;
            ph_q       <= 1'b0;
            sh_data_q  <= 32'd0;
            sh_blink_q <= 8'd0;
            sh_dp_q    <= 8'd0;
            an_q       <= 8'hFF;
            seg_q      <= 8'hFF;
        end else begin
            p_q        <= p_d;
            idx_q      <= idx_d;
            f_q        <= f_d;
            ph_q       <= ph_d;
            sh_data_q  <= sh_data_d;
            sh_blink_q <= sh_blink_d;
            sh_dp_q    <= sh_dp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;

endmodule

// File: tb/tb_seg_scan_blink.sv
// Bench for seg_scan_blink: a cycle-count based reference model predicts AN/SEG
// for directed scenarios and randomized stimulus.
module tb_seg_scan_blink;

    localparam int ST    = 4;
    localparam int BF    = 2;
    localparam int FRAME = 8 * ST;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        en    = 1'b0;
    logic [31:0] data  = 32'd0;
    logic [7:0]  blink = 8'd0;
    logic [7:0]  dp    = 8'd0;
    logic [7:0]  AN;
    logic [7:0]  SEG;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: edges since reset and the inputs captured at the last frame end.
    int          n = 0;
    logic [31:0] m_data  = 32'd0;
    logic [7:0]  m_blink = 8'd0;
    logic [7:0]  m_dp    = 8'd0;
    logic [7:0]  exp_an;
    logic [7:0]  exp_seg;

    always #5 clk = ~clk;

    seg_scan_blink #(
        .SCAN_TICKS  (ST),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .data (data),
        .blink(blink),
        .dp   (dp),
        .AN   (AN),
        .SEG  (SEG)
    );

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Predict the outputs for the coming edge, advance one clock, update the model.
    task automatic tick();
        logic        s_rst;
        logic [31:0] s_data;
        logic [7:0]  s_blink;
        logic [7:0]  s_dp;
        logic [7:0]  one;
        int          idx;
        int          ph;
        s_rst   = rst;
        s_data  = data;
        s_blink = blink;
        s_dp    = dp;
        idx     = (n / ST) % 8;
        ph      = ((n / FRAME) / BF) % 2;
        one     = 8'd1;
        if (rst || !en || (ph == 1 && m_blink[idx])) begin
            exp_an  = 8'hFF;
            exp_seg = 8'hFF;
        end else begin
            exp_an  = ~(one << idx);
            exp_seg = {~m_dp[idx], hex7(m_data[4*idx +: 4])};
        end
        @(posedge clk);
        #1;
        if (s_rst) begin
            n       = 0;
            m_data  = 32'd0;
            m_blink = 8'd0;
            m_dp    = 8'd0;
        end else begin
            n++;
            if (n % FRAME == 0) begin
                m_data  = s_data;
                m_blink = s_blink;
                m_dp    = s_dp;
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en   = 1'b1;
        data = 32'hDEADBEEF;
        dp   = 8'hFF;
        tick();
        n_checks++;
        if (AN !== 8'hFF || SEG !== 8'hFF)
            $display("FAIL reset_state AN=%h SEG=%h expected AN=ff SEG=ff", AN, SEG);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (AN !== 8'hFE || SEG !== 8'hC0)
            $display("FAIL reset_first_edge AN=%h SEG=%h expected AN=fe SEG=c0", AN, SEG);
        else n_pass++;
    endtask

    task automatic test_scan();
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; data = 32'h87654321; blink = 8'h00; dp = 8'h00;
        for (int c = 1; c <= 2 * FRAME; c++) begin
            tick();
            n_checks++;
            if (AN !== exp_an || SEG !== exp_seg)
                $display("FAIL scan c=%0d AN=%h SEG=%h expected AN=%h SEG=%h",
                         c, AN, SEG, exp_an, exp_seg);
            else n_pass++;
            if (c == 33) begin
                n_checks++;
                if (AN !== 8'hFE || SEG !== 8'hF9)
                    $display("FAIL scan_c33 AN=%h SEG=%h expected AN=fe SEG=f9", AN, SEG);
                else n_pass++;
            end
        end
    endtask

    task automatic test_blink();
        int dark_cnt;
        dark_cnt = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; data = 32'h0000000F; blink = 8'h01; dp = 8'h00;
        for (int c = 1; c <= 9 * FRAME; c++) begin
            tick();
            if (n > FRAME && ((n - 1) % FRAME) < ST && AN === 8'hFF) dark_cnt++;
            n_checks++;
            if (AN !== exp_an || SEG !== exp_seg)
                $display("FAIL blink n=%0d AN=%h SEG=%h expected AN=%h SEG=%h",
                         n, AN, SEG, exp_an, exp_seg);
            else n_pass++;
        end
        // Frames 2,3,6,7 are dark on digit 0: four frames of ST cycles each.
        n_checks++;
        if (dark_cnt !== 4 * ST)
            $display("FAIL blink_dark_cycles got %0d expected %0d", dark_cnt, 4 * ST);
        else n_pass++;
    endtask

    task automatic test_tearing();
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; data = 32'h11111111; blink = 8'h00; dp = 8'h00;
        for (int c = 1; c <= 3 * FRAME; c++) begin
            if (n == FRAME + 3 * ST) data = 32'h22222222;
            tick();
            n_checks++;
            if (AN !== exp_an || SEG !== exp_seg)
                $display("FAIL tearing n=%0d AN=%h SEG=%h expected AN=%h SEG=%h",
                         n, AN, SEG, exp_an, exp_seg);
            else n_pass++;
            if (n == 2 * FRAME) begin
                n_checks++;
                if (SEG !== 8'hF9)
                    $display("FAIL tearing_digit7 SEG=%h expected f9", SEG);
                else n_pass++;
            end
        end
    endtask

    task automatic test_enable();
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; data = $urandom; blink = 8'h00; dp = 8'h80;
        for (int c = 1; c <= 4 * FRAME; c++) begin
            en = !(n >= 2 * FRAME && n < 3 * FRAME);
            tick();
            n_checks++;
            if (AN !== exp_an || SEG !== exp_seg)
                $display("FAIL enable n=%0d AN=%h SEG=%h expected AN=%h SEG=%h",
                         n, AN, SEG, exp_an, exp_seg);
            else n_pass++;
            if (n == 4 * FRAME) begin
                n_checks++;
                if (AN !== 8'h7F || SEG[7] !== 1'b0)
                    $display("FAIL enable_dp7 AN=%h SEG=%h expected AN=7f SEG[7]=0", AN, SEG);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 2; k++) begin
            rst = 1'b1; tick(); rst = 1'b0;
            en = 1'b1; data = 32'h99999999; blink = 8'h00; dp = 8'hFF;
            // First pass: reset while digit 5 is driven; second: on the frame-end edge.
            while (n != ((k == 0) ? 5 * ST + 1 : FRAME - 1)) tick();
            data = 32'hABCDEF12;
            rst  = 1'b1;
            tick();
            n_checks++;
            if (AN !== 8'hFF || SEG !== 8'hFF)
                $display("FAIL rst_mid%0d AN=%h SEG=%h expected AN=ff SEG=ff", k, AN, SEG);
            else n_pass++;
            rst = 1'b0;
            for (int c = 1; c <= FRAME + ST; c++) begin
                tick();
                n_checks++;
                if (AN !== exp_an || SEG !== exp_seg)
                    $display("FAIL rst_mid%0d n=%0d AN=%h SEG=%h expected AN=%h SEG=%h",
                             k, n, AN, SEG, exp_an, exp_seg);
                else n_pass++;
                if (c == 1) begin
                    n_checks++;
                    if (SEG !== 8'hC0)
                        $display("FAIL rst_mid%0d_shadow SEG=%h expected c0", k, SEG);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            en    = ($urandom_range(0, 7) != 0);
            data  = $urandom;
            blink = 8'($urandom);
            dp    = 8'($urandom);
            tick();
            n_checks++;
            if (AN !== exp_an || SEG !== exp_seg)
                $display("FAIL random n=%0d AN=%h SEG=%h expected AN=%h SEG=%h",
                         n, AN, SEG, exp_an, exp_seg);
            else n_pass++;
            n_checks++;
            if ($countones(~AN) > 1 || (AN === 8'hFF && SEG !== 8'hFF))
                $display("FAIL invariant AN=%h SEG=%h expected one-cold AN, dark SEG=ff", AN, SEG);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blink();
        test_tearing();
        test_enable();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_blink.md
SEG_SCAN_BLINK -- requirements
Module: seg_scan_blink

Interface
REQ-001 SHALL have parameter SCAN_TICKS, default 100000; clk cycles each digit is driven (1 ms at 100 MHz), legal range 2..2^20.
REQ-002 SHALL have parameter BLINK_FRAMES, default 64; full 8-digit frames per blink half-period, legal range 1..255.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  display enable; low blanks all digits, counters keep running.
REQ-006 data  input  32  eight hex nibbles; data[4k+3:4k] shown on digit k.
REQ-007 blink  input  8  one-hot/any-hot mask; bit k set makes digit k blink.
REQ-008 dp  input  8  active-high decimal point request per digit.
REQ-009 AN  output  8  digit anodes, active-low, bit k = digit k, registered.
REQ-010 SEG  output  8  cathodes, active-low, order {DP,G,F,E,D,C,B,A}, registered.

Function
REQ-011 Prescaler p SHALL count 0..SCAN_TICKS-1; at p==SCAN_TICKS-1 p SHALL wrap to 0 and digit index idx (3 bits) SHALL increment modulo 8.
REQ-012 Frame end = p==SCAN_TICKS-1 and idx==7; on that edge data, blink, dp SHALL be loaded into shadow registers; no other edge alters shadows.
REQ-013 Mid-frame changes of data/blink/dp SHALL NOT affect display until next frame end (no tearing).
REQ-014 Frame counter f SHALL increment at each frame end; at f==BLINK_FRAMES-1 it SHALL wrap to 0 and blink phase ph SHALL toggle on the same edge.
REQ-015 AN/SEG SHALL be registered from current-cycle idx, shadows, ph, en: one clk latency after idx/shadow change.
REQ-016 Digit dark when en==0, or ph==1 and shadow_blink[idx]==1; dark -> AN=8'hFF, SEG=8'hFF.
REQ-017 Otherwise AN SHALL be all ones except bit idx=0; SEG[6:0] SHALL be hex pattern of shadow nibble idx; SEG[7]=~shadow_dp[idx].
REQ-018 Patterns SEG[6:0] (hex, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-019 Exactly zero or one AN bit SHALL be low in every cycle.
REQ-020 blink==0 SHALL give steady display regardless of ph; blink==8'hFF SHALL blank whole display during ph==1.
REQ-021 en SHALL NOT gate or reset p, idx, f, ph, or shadow loads.

Reset
REQ-022 rst high at an edge SHALL set p=0, idx=0, f=0, ph=0, all shadows=0, AN=8'hFF, SEG=8'hFF, overriding all other activity incl. a coincident frame end.
REQ-023 First edge after rst deasserts SHALL yield AN=8'hFE, SEG=8'hC0 (digit 0 showing "0", DP off) when en==1.
REQ-024 Reset asserted mid-frame SHALL discard partial frame; new data visible only after first full frame (8*SCAN_TICKS cycles) following reset.

Verification (SCAN_TICKS=4, BLINK_FRAMES=2)
REQ-025 rst 1 cycle, en=1, data=32'h87654321 held -> AN=FE SEG=C0 for 4 cycles, AN walks FD,FB..7F each 4 cycles all showing "0"; from cycle 33 AN=FE SEG=F9 ("1"), then A4,B0,99,92,82,F8 on digits 1..7.
REQ-026 Frame loaded with data=32'h0000000F, blink=8'h01 -> digit 0 shows 8E for frames 0-1 after load, fully dark (AN=FF) for next 2 frames, visible again after, period 4 frames=128 cycles.
REQ-027 data changed from 32'h11111111 to 32'h22222222 while idx==3 -> digits 3..7 of that frame still F9; change appears at digit 0 of next frame.
REQ-028 dp=8'h80, en toggled 0 for one full frame -> AN=FF SEG=FF throughout disabled frame; idx sequence and blink phase unchanged; digit 7 later shows SEG[7]=0.
REQ-029 rst asserted at idx==5 coincident with nothing else, and again exactly at a frame-end edge -> both cases AN=FF SEG=FF next cycle, shadows zero, no load of pending data.
REQ-030 Assertion over random stimulus: AN has at most one zero bit every cycle; AN==FF implies SEG==FF.
